// File: rtl/iic_slave_eeprom.sv
// IIC responder modelling a 24Cxx-style EEPROM: control byte, ADDR_BYTES word address, then byte writes or reads.
// Optional write-protect input i_wp is compiled in with `define IIC_SLAVE_WP_EN.
module iic_slave_eeprom #(
    parameter logic [6:0] DEV_ADDR   = 7'h57,
    parameter int         ADDR_BYTES = 2,
    parameter int         MEM_AW     = 8
) (
    input  logic              sys_clk,
    input  logic              rst,
`ifdef IIC_SLAVE_WP_EN
    input  logic              i_wp,
`endif
    input  logic              iic_scl,
    inout  wire               iic_sda,
    output logic              o_wr_done,
    output logic [MEM_AW-1:0] o_wr_addr,
    output logic [7:0]        o_wr_dat,
    output logic              o_busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_DEV, S_DEV_ACK, S_ADDR, S_ADDR_ACK,
        S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_WAIT_STOP
    } state_t;

    state_t            r_state;
    logic [2:0]        r_scl_q, r_sda_q;
    logic [3:0]        r_cnt;
    logic [7:0]        r_shift;
    logic              r_rw, r_ack_ph, r_sda_oe;
    logic [1:0]        r_abyte;
    logic [MEM_AW-1:0] r_waddr, r_ptr;
    logic [7:0]        r_mem [2**MEM_AW];

    logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_sda, w_wp, w_mem_we;
    logic [7:0] w_byte;

    // [1] is the synchronized level, [2] its previous value for edge detection
    assign w_sda      = r_sda_q[1];
    assign w_scl_rise =  r_scl_q[1] & ~r_scl_q[2];
    assign w_scl_fall = ~r_scl_q[1] &  r_scl_q[2];
    assign w_start    = r_scl_q[1] & r_scl_q[2] & ~r_sda_q[1] &  r_sda_q[2];
    assign w_stop     = r_scl_q[1] & r_scl_q[2] &  r_sda_q[1] & ~r_sda_q[2];
    assign w_byte     = {r_shift[6:0], w_sda};
    assign iic_sda    = r_sda_oe ? 1'b0 : 1'bz;

`ifdef IIC_SLAVE_WP_EN
    logic [1:0] r_wp_q;
    always_ff @(posedge sys_clk) begin
        if (rst) r_wp_q <= '0;
        else     r_wp_q <= {r_wp_q[0], i_wp};
    end
    assign w_wp = r_wp_q[1];
`else
    assign w_wp = 1'b0;
`endif

    assign w_mem_we = ~rst & (r_state == S_WR) & w_scl_rise & (r_cnt == 4'd7) & ~w_wp;

    always_ff @(posedge sys_clk) begin
        if (w_mem_we) r_mem[r_ptr] <= w_byte;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_scl_q   <= '1;
            r_sda_q   <= '1;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_rw      <= 1'b0;
            r_ack_ph  <= 1'b0;
            r_abyte   <= '0;
            r_waddr   <= '0;
            r_ptr     <= '0;
            r_sda_oe  <= 1'b0;
            o_busy    <= 1'b0;
            o_wr_done <= 1'b0;
            o_wr_addr <= '0;
            o_wr_dat  <= '0;
        end else begin
            r_scl_q   <= {r_scl_q[1:0], iic_scl};
            r_sda_q   <= {r_sda_q[1:0], iic_sda};
            o_wr_done <= 1'b0;
            if (w_start) begin
                r_state  <= S_DEV;
                r_cnt    <= '0;
                r_ack_ph <= 1'b0;
                r_sda_oe <= 1'b0;
            end else if (w_stop) begin
                r_state  <= S_IDLE;
                r_sda_oe <= 1'b0;
                o_busy   <= 1'b0;
            end else begin
                case (r_state)
                    S_DEV: if (w_scl_rise) begin
                        r_shift <= w_byte;
                        r_cnt   <= r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            if (w_byte[7:1] == DEV_ADDR) begin
                                o_busy   <= 1'b1;
                                r_rw     <= w_byte[0];
                                r_ack_ph <= 1'b0;
                                r_state  <= S_DEV_ACK;
                            end else begin
                                r_state  <= S_WAIT_STOP;
                            end
                        end
                    end
                    S_ADDR: if (w_scl_rise) begin
                        r_shift <= w_byte;
                        r_cnt   <= r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            // keep only the low MEM_AW bits of the word address
                            r_waddr <= MEM_AW'({r_waddr, w_byte});
                            r_state <= S_ADDR_ACK;
                        end
                    end
                    S_WR: if (w_scl_rise) begin
                        r_shift <= w_byte;
                        r_cnt   <= r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            if (!w_wp) begin
                                o_wr_done <= 1'b1;
                                o_wr_addr <= r_ptr;
                                o_wr_dat  <= w_byte;
                            end
                            r_ptr   <= r_ptr + 1'b1;
                            r_state <= S_WR_ACK;
                        end
                    end
                    S_DEV_ACK, S_ADDR_ACK, S_WR_ACK: if (w_scl_fall) begin
                        // first fall starts the ACK, second fall ends it and hands over the bus
                        if (!r_ack_ph) begin
                            r_sda_oe <= 1'b1;
                            r_ack_ph <= 1'b1;
                        end else begin
                            r_sda_oe <= 1'b0;
                            r_ack_ph <= 1'b0;
                            r_cnt    <= '0;
                            if (r_state == S_DEV_ACK) begin
                                if (r_rw) begin
                                    r_shift  <= r_mem[r_ptr];
                                    r_sda_oe <= ~r_mem[r_ptr][7];
                                    r_state  <= S_RD;
                                end else begin
                                    r_abyte  <= '0;
                                    r_waddr  <= '0;
                                    r_state  <= S_ADDR;
                                end
                            end else if (r_state == S_ADDR_ACK) begin
                                if (r_abyte == 2'(ADDR_BYTES - 1)) begin
                                    r_ptr   <= r_waddr;
                                    r_state <= S_WR;
                                end else begin
                                    r_abyte <= r_abyte + 2'd1;
                                    r_state <= S_ADDR;
                                end
                            end else begin
                                r_state <= S_WR;
                            end
                        end
                    end
                    S_RD: begin
                        if (w_scl_rise) r_cnt <= r_cnt + 4'd1;
                        if (w_scl_fall) begin
                            if (r_cnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                                r_ack_ph <= 1'b0;
                                r_state  <= S_RD_ACK;
                            end else begin
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_sda_oe <= ~r_shift[6];
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda) begin
                                r_state <= S_WAIT_STOP;
                            end else begin
                                r_ptr    <= r_ptr + 1'b1;
                                r_ack_ph <= 1'b1;
                            end
                        end else if (w_scl_fall && r_ack_ph) begin
                            r_shift  <= r_mem[r_ptr];
                            r_sda_oe <= ~r_mem[r_ptr][7];
                            r_cnt    <= '0;
                            r_ack_ph <= 1'b0;
                            r_state  <= S_RD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iic_slave_eeprom.sv
// Bit-banged IIC master driving iic_slave_eeprom, checked against a byte-array EEPROM model.
module tb_iic_slave_eeprom;
    localparam int Q = 10;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda_oe = 1'b0;
    wire        sda;
    logic       o_wr_done;
    logic [7:0] o_wr_addr, o_wr_dat;
    logic       o_busy;
`ifdef IIC_SLAVE_WP_EN
    logic       wp = 1'b0;
`endif

    pullup (sda);
    assign sda = m_sda_oe ? 1'b0 : 1'bz;

    iic_slave_eeprom dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
`ifdef IIC_SLAVE_WP_EN
        .i_wp      (wp),
`endif
        .iic_scl   (scl),
        .iic_sda   (sda),
        .o_wr_done (o_wr_done),
        .o_wr_addr (o_wr_addr),
        .o_wr_dat  (o_wr_dat),
        .o_busy    (o_busy)
    );

    initial forever #5 sys_clk = ~sys_clk;

    int          n_tests = 0, n_fail = 0;
    logic [7:0]  mem_m [256];
    logic [15:0] done_q [$];
    logic [15:0] exp_q  [$];
    logic [7:0]  wbuf [8];
    logic [7:0]  rbuf [8];
    logic        busy_seen, rel_seen;

    always @(negedge sys_clk) if (o_wr_done === 1'b1) done_q.push_back({o_wr_addr, o_wr_dat});

    task automatic hc(input int n);
        repeat (n) @(posedge sys_clk);
    endtask

    task automatic m_start();
        m_sda_oe = 1'b0; hc(Q);
        scl = 1'b1;      hc(Q);
        m_sda_oe = 1'b1; hc(Q);
        scl = 1'b0;      hc(Q);
    endtask

    task automatic m_stop();
        m_sda_oe = 1'b1; hc(Q);
        scl = 1'b1;      hc(Q);
        m_sda_oe = 1'b0; hc(Q);
    endtask

    task automatic m_wbyte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda_oe = ~b[i]; hc(Q);
            scl = 1'b1;       hc(Q);
            scl = 1'b0;       hc(Q/2);
        end
        m_sda_oe = 1'b0; hc(Q);
        scl = 1'b1;      hc(Q/2);
        @(negedge sys_clk) ack = sda;
        hc(Q/2);
        scl = 1'b0;      hc(Q/2);
    endtask

    task automatic m_rbyte(input logic nack, output logic [7:0] b, output logic rel);
        m_sda_oe = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            hc(Q);
            scl = 1'b1; hc(Q/2);
            @(negedge sys_clk) b[i] = sda;
            hc(Q/2);
            scl = 1'b0; hc(Q/2);
        end
        m_sda_oe = ~nack; hc(Q);
        @(negedge sys_clk) rel = sda;
        scl = 1'b1; hc(Q);
        scl = 1'b0; hc(Q/2);
        m_sda_oe = 1'b0; hc(Q/2);
    endtask

    // Writes n bytes of wbuf at addr; store=0 means a protected write the model must not record
    task automatic wr_txn(input logic [15:0] addr, input int n, input bit store, output int nacks);
        logic a;
        nacks = 0;
        m_start();
        m_wbyte(8'hAE, a); nacks += int'(a);
        @(negedge sys_clk) busy_seen = o_busy;
        m_wbyte(addr[15:8], a); nacks += int'(a);
        m_wbyte(addr[7:0], a);  nacks += int'(a);
        for (int i = 0; i < n; i++) begin
            m_wbyte(wbuf[i], a); nacks += int'(a);
            if (store) begin
                mem_m[8'(addr + 16'(i))] = wbuf[i];
                exp_q.push_back({8'(addr + 16'(i)), wbuf[i]});
            end
        end
        m_stop();
    endtask

    task automatic rd_txn(input logic [15:0] addr, input int n, output int nacks);
        logic a;
        nacks = 0;
        m_start();
        m_wbyte(8'hAE, a); nacks += int'(a);
        m_wbyte(addr[15:8], a); nacks += int'(a);
        m_wbyte(addr[7:0], a);  nacks += int'(a);
        m_start();
        m_wbyte(8'hAF, a); nacks += int'(a);
        @(negedge sys_clk) busy_seen = o_busy;
        for (int i = 0; i < n; i++) m_rbyte(i == n - 1, rbuf[i], rel_seen);
        m_stop();
    endtask

    task automatic check_done(input string name);
        n_tests++;
        if (done_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s: wr_done pulses got %0d expected %0d", name, done_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (done_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL %s: commit %0d got %h expected %h", name, i, done_q[i], exp_q[i]);
                end
            end
        end
        done_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; hc(3);
        @(negedge sys_clk) rst = 1'b0;
        hc(2);
        @(negedge sys_clk);
        n_tests++; if (o_wr_done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b expected 0", o_wr_done); end
        n_tests++; if (o_wr_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h expected 00", o_wr_addr); end
        n_tests++; if (o_wr_dat !== 8'h00)  begin n_fail++; $display("FAIL reset_dat: got %h expected 00", o_wr_dat); end
        n_tests++; if (o_busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        n_tests++; if (sda !== 1'b1)        begin n_fail++; $display("FAIL reset_sda: got %b expected 1", sda); end
    endtask

    task automatic test_write_basic();
        int nk;
        done_q.delete(); exp_q.delete();
        wbuf[0] = 8'hE1;
        wr_txn(16'hE6AD, 1, 1'b1, nk);
        n_tests++; if (nk != 0) begin n_fail++; $display("FAIL wr_basic_acks: got %0d nacks expected 0", nk); end
        n_tests++; if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL wr_basic_busy: got %b expected 1", busy_seen); end
        check_done("wr_basic");
    endtask

    task automatic test_random_read();
        int nk;
        rd_txn(16'hE6AD, 1, nk);
        n_tests++; if (nk != 0) begin n_fail++; $display("FAIL rd_acks: got %0d nacks expected 0", nk); end
        n_tests++; if (rbuf[0] !== mem_m[8'hAD]) begin n_fail++; $display("FAIL rd_data: got %h expected %h", rbuf[0], mem_m[8'hAD]); end
        n_tests++; if (rel_seen !== 1'b1) begin n_fail++; $display("FAIL rd_release: sda %b expected 1", rel_seen); end
        @(negedge sys_clk);
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_after_p: got %b expected 0", o_busy); end
        check_done("rd_nowrite");
    endtask

    task automatic test_write_read_00();
        int nk;
        wbuf[0] = 8'hA5;
        wr_txn(16'h0000, 1, 1'b1, nk);
        check_done("wr00");
        rd_txn(16'h0000, 1, nk);
        n_tests++; if (rbuf[0] !== 8'hA5) begin n_fail++; $display("FAIL rd00: got %h expected a5", rbuf[0]); end
        rd_txn(16'hE6AD, 1, nk);
        n_tests++; if (rbuf[0] !== 8'hE1) begin n_fail++; $display("FAIL rdAD_kept: got %h expected e1", rbuf[0]); end
    endtask

    task automatic test_bad_dev();
        logic a;
        m_start();
        m_wbyte(8'hA0, a);
        n_tests++; if (a !== 1'b1) begin n_fail++; $display("FAIL bad_dev_nack: got %b expected 1", a); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL bad_dev_busy: got %b expected 0", o_busy); end
        m_wbyte(8'h33, a);
        m_stop();
        check_done("bad_dev_nowrite");
        m_start();
        m_wbyte(8'hAE, a);
        n_tests++; if (a !== 1'b0) begin n_fail++; $display("FAIL bad_dev_recover: got %b expected 0", a); end
        m_stop();
    endtask

    task automatic test_wrap();
        int nk;
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        wr_txn(16'h00FF, 2, 1'b1, nk);
        n_tests++; if (nk != 0) begin n_fail++; $display("FAIL wrap_acks: got %0d nacks expected 0", nk); end
        check_done("wrap_wr");
        rd_txn(16'h00FF, 2, nk);
        n_tests++; if (rbuf[0] !== 8'h11) begin n_fail++; $display("FAIL wrap_rd0: got %h expected 11", rbuf[0]); end
        n_tests++; if (rbuf[1] !== 8'h22) begin n_fail++; $display("FAIL wrap_rd1: got %h expected 22", rbuf[1]); end
    endtask

    task automatic test_random();
        int nk, len;
        logic [15:0] a;
        for (int it = 0; it < 5; it++) begin
            len = $urandom_range(1, 3);
            a   = 16'($urandom);
            for (int i = 0; i < len; i++) wbuf[i] = 8'($urandom);
            wr_txn(a, len, 1'b1, nk);
            n_tests++; if (nk != 0) begin n_fail++; $display("FAIL rand_wr_acks it%0d: got %0d expected 0", it, nk); end
            check_done("rand_wr");
            rd_txn(a, len, nk);
            for (int i = 0; i < len; i++) begin
                n_tests++;
                if (rbuf[i] !== mem_m[8'(a + 16'(i))]) begin
                    n_fail++;
                    $display("FAIL rand_rd it%0d byte%0d: got %h expected %h", it, i, rbuf[i], mem_m[8'(a + 16'(i))]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int nk;
        logic a;
        logic [7:0] b;
        wbuf[0] = 8'h00;
        wr_txn(16'h0040, 1, 1'b1, nk);
        check_done("mid_setup");
        m_start();
        m_wbyte(8'hAE, a); m_wbyte(8'h00, a); m_wbyte(8'h40, a);
        m_start();
        m_wbyte(8'hAF, a);
        @(negedge sys_clk);
        n_tests++; if (sda !== 1'b0) begin n_fail++; $display("FAIL mid_driving: sda %b expected 0", sda); end
        rst = 1'b1;
        @(negedge sys_clk) rst = 1'b0;
        n_tests++; if (sda !== 1'b1) begin n_fail++; $display("FAIL mid_release: sda %b expected 1", sda); end
        n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b expected 0", o_busy); end
        n_tests++; if (o_wr_addr !== 8'h00) begin n_fail++; $display("FAIL mid_addr: got %h expected 00", o_wr_addr); end
        hc(Q);
        m_stop();
        // pointer is back at 0 after reset, so a current-address read returns mem[0]
        m_start();
        m_wbyte(8'hAF, a);
        n_tests++; if (a !== 1'b0) begin n_fail++; $display("FAIL mid_restart_ack: got %b expected 0", a); end
        m_rbyte(1'b1, b, rel_seen);
        m_stop();
        n_tests++; if (b !== mem_m[0]) begin n_fail++; $display("FAIL mid_ptr0: got %h expected %h", b, mem_m[0]); end
    endtask

`ifdef IIC_SLAVE_WP_EN
    task automatic test_wp();
        int nk;
        wbuf[0] = 8'h3C;
        wr_txn(16'h0010, 1, 1'b1, nk);
        check_done("wp_setup");
        wp = 1'b1;
        wbuf[0] = 8'h5A;
        wr_txn(16'h0010, 1, 1'b0, nk);
        n_tests++; if (nk != 0) begin n_fail++; $display("FAIL wp_acks: got %0d nacks expected 0", nk); end
        check_done("wp_nowrite");
        wp = 1'b0;
        rd_txn(16'h0010, 1, nk);
        n_tests++; if (rbuf[0] !== 8'h3C) begin n_fail++; $display("FAIL wp_readback: got %h expected 3c", rbuf[0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_basic();
        test_random_read();
        test_write_read_00();
        test_bad_dev();
        test_wrap();
        test_random();
        test_reset_mid();
`ifdef IIC_SLAVE_WP_EN
        test_wp();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
